// File: rtl/st_32_to_64_bits_dfa_pkg.sv
// Shared definitions for the 32-to-64-bit Avalon-ST data format adapter.
// Symbol order is big-endian on both sides: the first symbol of a beat
// occupies the most significant byte lane ([31:24] in, [63:56] out).
package st_dfa_pkg;

  localparam int SYMBOL_W    = 8;
  localparam int IN_SYMBOLS  = 4;
  localparam int OUT_SYMBOLS = 2 * IN_SYMBOLS;
  localparam int IN_DATA_W   = SYMBOL_W * IN_SYMBOLS;
  localparam int OUT_DATA_W  = SYMBOL_W * OUT_SYMBOLS;
  localparam int IN_EMPTY_W  = $clog2(IN_SYMBOLS);
  localparam int OUT_EMPTY_W = $clog2(OUT_SYMBOLS);

  // S_HI: next accepted beat becomes the upper half of an output word.
  // S_LO: an upper half is held and the next beat completes the word.
  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } dfa_state_e;

  // Empty count for a word whose lower half is all padding (eop in S_HI).
  function automatic logic [OUT_EMPTY_W-1:0] upper_only_empty(
    input logic [IN_EMPTY_W-1:0] in_empty
  );
    return OUT_EMPTY_W'({1'b0, in_empty}) + OUT_EMPTY_W'(IN_SYMBOLS);
  endfunction

  // Empty count for a word completed in S_LO; zero unless it ends a packet.
  function automatic logic [OUT_EMPTY_W-1:0] lower_half_empty(
    input logic                  eop,
    input logic [IN_EMPTY_W-1:0] in_empty
  );
    logic [OUT_EMPTY_W-1:0] res;
    if (eop) begin
      res = OUT_EMPTY_W'({1'b0, in_empty});
    end else begin
      res = {OUT_EMPTY_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/st_32_to_64_bits_dfa_if.sv
// Avalon-ST stream bundle (ready latency 0) used on both sides of the
// adapter. The master drives the beat, the slave drives ready.
interface st_32_to_64_bits_dfa_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);

  logic               ready;
  logic               valid;
  logic [DATA_W-1:0]  data;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output valid, data, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, data, startofpacket, endofpacket, empty,
    output ready
  );

endinterface

// File: rtl/st_32_to_64_bits_dfa.sv
// Packs a 32-bit (4-symbol) Avalon-ST stream into a 64-bit (8-symbol) one.
// Two input beats form one output word; an eop beat landing in the upper
// half is flushed immediately with a zero lower half. The output stage is a
// single register slice that advances whenever it is empty or drained.
module st_32_to_64_bits_dfa
  import st_dfa_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  st_32_to_64_bits_dfa_if.slave  in_st,
  st_32_to_64_bits_dfa_if.master out_st,
  output logic                   protocol_error
);

  dfa_state_e             state_r;
  dfa_state_e             state_nxt_s;
  logic [IN_DATA_W-1:0]   hold_data_r;
  logic                   hold_sop_r;
  logic                   load_hold_s;

  logic                   advance_s;
  logic                   accept_s;
  logic                   emit_s;
  logic [OUT_DATA_W-1:0]  emit_data_s;
  logic                   emit_sop_s;
  logic                   emit_eop_s;
  logic [OUT_EMPTY_W-1:0] emit_empty_s;
  logic                   perr_set_s;

  logic                   out_valid_r;
  logic [OUT_DATA_W-1:0]  out_data_r;
  logic                   out_sop_r;
  logic                   out_eop_r;
  logic [OUT_EMPTY_W-1:0] out_empty_r;
  logic                   protocol_error_r;

  // Output slice can take a new word when empty or being drained this cycle;
  // input ready follows it directly so nothing is accepted that can't land.
  assign advance_s   = out_st.ready | ~out_valid_r;
  assign in_st.ready = advance_s;
  assign accept_s    = in_st.valid & advance_s;

  // Next-state and emitted-word selection for the half-word packer.
  always_comb begin
    state_nxt_s  = state_r;
    load_hold_s  = 1'b0;
    emit_s       = 1'b0;
    emit_data_s  = {OUT_DATA_W{1'b0}};
    emit_sop_s   = 1'b0;
    emit_eop_s   = 1'b0;
    emit_empty_s = {OUT_EMPTY_W{1'b0}};
    perr_set_s   = 1'b0;
    case (state_r)
      S_HI: begin
        if (accept_s) begin
          if (in_st.endofpacket) begin
            emit_s       = 1'b1;
            emit_data_s  = {in_st.data, {IN_DATA_W{1'b0}}};
            emit_sop_s   = in_st.startofpacket;
            emit_eop_s   = 1'b1;
            emit_empty_s = upper_only_empty(in_st.empty);
            state_nxt_s  = S_HI;
          end else begin
            load_hold_s  = 1'b1;
            state_nxt_s  = S_LO;
          end
        end else begin
          state_nxt_s = S_HI;
        end
      end
      S_LO: begin
        if (accept_s) begin
          // A sop here is merged as data anyway; only the error flag records it.
          emit_s       = 1'b1;
          emit_data_s  = {hold_data_r, in_st.data};
          emit_sop_s   = hold_sop_r;
          emit_eop_s   = in_st.endofpacket;
          emit_empty_s = lower_half_empty(in_st.endofpacket, in_st.empty);
          perr_set_s   = in_st.startofpacket;
          state_nxt_s  = S_HI;
        end else begin
          state_nxt_s = S_LO;
        end
      end
      default: begin
        state_nxt_s = S_HI;
      end
    endcase
  end

  // Packer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_HI;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Upper-half hold registers, loaded when a non-eop beat arrives in S_HI.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_r <= {IN_DATA_W{1'b0}};
      hold_sop_r  <= 1'b0;
    end else if (load_hold_s) begin
      hold_data_r <= in_st.data;
      hold_sop_r  <= in_st.startofpacket;
    end
  end

  // Output register slice; holds its word steady under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_DATA_W{1'b0}};
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_empty_r <= {OUT_EMPTY_W{1'b0}};
    end else if (advance_s) begin
      out_valid_r <= emit_s;
      out_data_r  <= emit_data_s;
      out_sop_r   <= emit_sop_s;
      out_eop_r   <= emit_eop_s;
      out_empty_r <= emit_empty_s;
    end
  end

  // Sticky framing error: sop arrived while an upper half was pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_error_r <= 1'b0;
    end else if (perr_set_s) begin
      protocol_error_r <= 1'b1;
    end
  end

  assign out_st.valid         = out_valid_r;
  assign out_st.data          = out_data_r;
  assign out_st.startofpacket = out_sop_r;
  assign out_st.endofpacket   = out_eop_r;
  assign out_st.empty         = out_empty_r;
  assign protocol_error       = protocol_error_r;

endmodule
